// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the demux channel sequencer.
package demux_pkg;

   localparam int unsigned N_CH    = 32;
   localparam int unsigned CH_W    = 5;
   localparam int unsigned DWELL_W = 24;

   // Number of examinations after which a search has covered every channel.
   localparam logic [CH_W:0] SEARCH_ALL = (CH_W + 1)'(N_CH);

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      ISSUE,
      DWELL
   } seq_state_t;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that parks at zero; zero flags an expired count.
module dwell_timer #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/demux_sequencer.sv
// Walks a latched channel mask in ascending order, issuing each enabled channel
// over valid/ready and dwelling a fixed number of cycles after each acceptance.
module demux_sequencer
   import demux_pkg::*;
#(
   parameter logic [DWELL_W-1:0] DWELL_CYCLES = 24'd2000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stop,
   input  logic [N_CH-1:0] ch_mask,
   input  logic            ch_ready,
   output logic            ch_valid,
   output logic [CH_W-1:0] ch,
   output logic            busy,
   output logic            scan_done,
   output logic            mask_err
);

   seq_state_t      state_q;
   logic [N_CH-1:0] mask_q;
   logic [CH_W-1:0] ptr_q;
   logic [CH_W:0]   tried_q;
   logic            handshake;
   logic            dwell_load;
   logic            dwell_zero;

   // ch_valid is registered and only high in ISSUE, so no ready-to-valid path exists.
   assign handshake  = ch_valid & ch_ready;
   assign dwell_load = (state_q == ISSUE) & handshake;

   dwell_timer #(
      .W (DWELL_W)
   ) u_dwell_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (dwell_load),
      .load_val (DWELL_CYCLES - DWELL_W'(1)),
      .zero     (dwell_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mask_q    <= '0;
         ptr_q     <= '0;
         tried_q   <= '0;
         ch_valid  <= 1'b0;
         ch        <= '0;
         busy      <= 1'b0;
         scan_done <= 1'b0;
         mask_err  <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         mask_err  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start && !stop) begin
                  mask_q  <= ch_mask;
                  ptr_q   <= '0;
                  tried_q <= '0;
                  busy    <= 1'b1;
                  state_q <= SEARCH;
               end
            end
            SEARCH: begin
               if (stop) begin
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end else if (tried_q == SEARCH_ALL) begin
                  mask_err <= 1'b1;
                  busy     <= 1'b0;
                  state_q  <= IDLE;
               end else if (mask_q[ptr_q]) begin
                  ch       <= ptr_q;
                  ch_valid <= 1'b1;
                  state_q  <= ISSUE;
               end else begin
                  ptr_q     <= ptr_q + 1'b1;
                  tried_q   <= tried_q + 1'b1;
                  scan_done <= (ptr_q == '1);
               end
            end
            ISSUE: begin
               // A pending request is never withdrawn; stop only redirects the exit.
               if (handshake) begin
                  ch_valid <= 1'b0;
                  if (stop) begin
                     busy    <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     state_q <= DWELL;
                  end
               end
            end
            DWELL: begin
               if (stop) begin
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end else if (dwell_zero) begin
                  ptr_q     <= ch + 1'b1;
                  tried_q   <= '0;
                  scan_done <= (ch == '1);
                  state_q   <= SEARCH;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_demux_sequencer.sv
// Directed bench for demux_sequencer with a short dwell; expected gaps are hand-derived.
module tb_demux_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic [31:0] ch_mask;
   logic        ch_ready;
   logic        ch_valid;
   logic [4:0]  ch;
   logic        busy;
   logic        scan_done;
   logic        mask_err;

   int checks;
   int failures;

   demux_sequencer #(
      .DWELL_CYCLES (24'd4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .ch_mask   (ch_mask),
      .ch_ready  (ch_ready),
      .ch_valid  (ch_valid),
      .ch        (ch),
      .busy      (busy),
      .scan_done (scan_done),
      .mask_err  (mask_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Counts edges until a request is seen (and, unless any_valid, until it will be accepted).
   task automatic await_req(input bit any_valid, output int gap, output int sd);
      gap = 0;
      sd  = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         gap++;
         if (scan_done) sd++;
      end while (!(ch_valid && (ch_ready || any_valid)) && gap < 200);
   endtask

   int gap, sd, n, errs, vs;
   logic [4:0]  exp_ch  [4] = '{5'd2, 5'd0, 5'd2, 5'd0};
   int          exp_gap [4] = '{7, 35, 7, 35};
   int          exp_sd  [4] = '{0, 1, 0, 1};

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      start    = 1'b0;
      stop     = 1'b0;
      ch_mask  = '0;
      ch_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_valid", ch_valid, 0);
      check_eq("rst_ch", ch, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_scan_done", scan_done, 0);
      check_eq("rst_mask_err", mask_err, 0);
      rst = 1'b0;

      // start and stop together: stop wins
      ch_mask = 32'h1;
      start   = 1'b1;
      stop    = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("startstop_busy", busy, 0);
      check_eq("startstop_valid", ch_valid, 0);
      start = 1'b0;
      stop  = 1'b0;
      @(negedge clk);

      // mask 0x5: sequence 0,2,0,2 with scan_done after each visit to 2
      ch_mask  = 32'h0000_0005;
      ch_ready = 1'b1;
      start    = 1'b1;
      await_req(1'b0, gap, sd);
      check_eq("m5_first_gap", gap, 2);
      check_eq("m5_first_ch", ch, 0);
      ch_mask = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         await_req(1'b0, gap, sd);
         check_eq($sformatf("m5_gap%0d", i), gap, exp_gap[i]);
         check_eq($sformatf("m5_ch%0d", i), ch, exp_ch[i]);
         check_eq($sformatf("m5_sd%0d", i), sd, exp_sd[i]);
      end

      // stop during DWELL
      @(negedge clk);
      check_eq("dwell_busy", busy, 1);
      stop = 1'b1;
      @(negedge clk);
      check_eq("stop_dwell_busy", busy, 0);
      check_eq("stop_dwell_valid", ch_valid, 0);
      stop = 1'b0;
      @(negedge clk);

      // empty mask: 33 busy cycles and a single mask_err
      ch_mask = '0;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n     = 0;
      errs  = 0;
      vs    = 0;
      while (busy && n < 100) begin
         n++;
         if (mask_err) errs++;
         if (ch_valid) vs++;
         @(negedge clk);
      end
      if (mask_err) errs++;
      @(negedge clk);
      if (mask_err) errs++;
      check_eq("m0_busy_cycles", n, 33);
      check_eq("m0_mask_err", errs, 1);
      check_eq("m0_valid", vs, 0);

      // mask 0x8000_0001: held request, then channel 31, then wrap to 0
      ch_mask  = 32'h8000_0001;
      ch_ready = 1'b0;
      start    = 1'b1;
      await_req(1'b1, gap, sd);
      check_eq("hold_gap", gap, 2);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ch_valid && ch == 5'd0) n++;
      end
      check_eq("hold_stable", n, 10);
      ch_ready = 1'b1;
      await_req(1'b0, gap, sd);
      check_eq("m31_gap", gap, 36);
      check_eq("m31_ch", ch, 31);
      check_eq("m31_sd", sd, 0);
      await_req(1'b0, gap, sd);
      check_eq("wrap_gap", gap, 6);
      check_eq("wrap_ch", ch, 0);
      check_eq("wrap_sd", sd, 1);
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;

      // stop during ISSUE with ready low: hold, then IDLE without dwelling
      ch_mask  = 32'h0000_0002;
      ch_ready = 1'b0;
      start    = 1'b1;
      await_req(1'b1, gap, sd);
      check_eq("issue_gap", gap, 3);
      check_eq("issue_ch", ch, 1);
      stop = 1'b1;
      n    = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (ch_valid && busy) n++;
      end
      check_eq("stop_issue_hold", n, 3);
      ch_ready = 1'b1;
      @(negedge clk);
      check_eq("stop_issue_busy", busy, 0);
      check_eq("stop_issue_valid", ch_valid, 0);
      stop = 1'b0;
      n    = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy) n++;
      end
      check_eq("stop_issue_idle", n, 0);

      // reset mid-ISSUE with ready high: no handshake, outputs cleared
      ch_mask  = 32'h0000_0004;
      ch_ready = 1'b0;
      start    = 1'b1;
      await_req(1'b1, gap, sd);
      check_eq("ri_ch", ch, 2);
      rst      = 1'b1;
      ch_ready = 1'b1;
      @(negedge clk);
      check_eq("ri_valid", ch_valid, 0);
      check_eq("ri_ch_rst", ch, 0);
      check_eq("ri_busy", busy, 0);
      check_eq("ri_scan_done", scan_done, 0);
      check_eq("ri_mask_err", mask_err, 0);
      rst = 1'b0;
      @(negedge clk);

      // reset mid-DWELL, then a fresh start latches the new mask
      start = 1'b1;
      await_req(1'b0, gap, sd);
      check_eq("rd_gap", gap, 4);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rd_busy", busy, 0);
      check_eq("rd_valid", ch_valid, 0);
      check_eq("rd_ch", ch, 0);
      rst     = 1'b0;
      ch_mask = 32'h0000_0008;
      start   = 1'b1;
      await_req(1'b0, gap, sd);
      check_eq("new_gap", gap, 5);
      check_eq("new_ch", ch, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/demux_sequencer.md
# demux_sequencer

Upstream channel scheduler for the 32-channel analog demux driver. It walks a latched 32-bit channel-enable mask in ascending order and hands each enabled channel number to the driver over a valid/ready handshake. After each accepted channel it holds off for a programmable dwell time, then moves to the next enabled channel, wrapping 31→0 until stopped.

## Interface
- `DWELL_CYCLES`, default 24'd2000000: clock cycles between handshake acceptance and the next search; legal range 1 to 2^24-1.
- `clk`  in  1: board clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: level sampled each cycle; starts a scan when IDLE.
- `stop`  in  1: level sampled each cycle; requests a return to IDLE.
- `ch_mask`  in  32: bit n set means channel n is enabled; latched only on an accepted `start`.
- `ch_ready`  in  1: the downstream driver accepts `ch`.
- `ch_valid`  out  1: `ch` holds a pending channel request.
- `ch`  out  5: requested channel number.
- `busy`  out  1: high in every state except IDLE.
- `scan_done`  out  1: one-cycle pulse when the scan pointer wraps from 31 to 0.
- `mask_err`  out  1: one-cycle pulse when a full search finds no enabled channel.

## Operation
- States:
  - IDLE
  - SEARCH
  - ISSUE
  - DWELL
- Registers:
  - `mask_q[31:0]`: latched mask.
  - `ptr[4:0]`: search pointer.
  - `tried[5:0]`: channels examined in the current search.
  - `cnt[23:0]`: dwell counter.
- IDLE: on `start`=1 and `stop`=0, set `mask_q`←`ch_mask`, `ptr`←0, `tried`←0, go to SEARCH. If `start` and `stop` are both high, `stop` wins and the block stays in IDLE.
- SEARCH examines one channel per cycle:
  - If `mask_q[ptr]`=1: `ch`←`ptr`, go to ISSUE.
  - Otherwise: `ptr`←`ptr`+1 (mod 32), `tried`←`tried`+1.
  - If `tried` reaches 32 (`mask_q`=0): go to IDLE and pulse `mask_err`.
- ISSUE: `ch_valid`=1 and `ch` stays stable until `ch_valid`&`ch_ready`. On that handshake, `cnt`←`DWELL_CYCLES`-1 and go to DWELL.
- DWELL:
  - While `cnt`≠0: decrement `cnt`.
  - When `cnt`=0: `ptr`←`ch`+1 (mod 32), `tried`←0, go to SEARCH.
- `scan_done` pulses in the cycle after any `ptr` update from 31 to 0, whether the update happens in SEARCH or at DWELL exit.
- `stop` behaviour:
  - In SEARCH or DWELL: go to IDLE next edge.
  - In ISSUE: the request is never withdrawn. The block goes to IDLE on the handshake edge instead of DWELL, or stays in ISSUE if `ch_ready` stays 0.
- `start` while `busy` is ignored. `ch_mask` changes while `busy` have no effect.
- `ch_valid` never depends combinationally on `ch_ready`.

## Timing
- Reset values:
  - state IDLE.
  - `ch_valid`=0, `ch`=0, `busy`=0, `scan_done`=0, `mask_err`=0.
  - `mask_q`=0, `ptr`=0, `cnt`=0.
- Reset asserted mid-ISSUE drops `ch_valid` at the next edge. No handshake completes on that edge.
- Latency from `start` sampled (edge E) to `ch_valid`:
  - E+1: SEARCH.
  - E+2: first ISSUE cycle, when channel 0 is enabled.
  - Each disabled channel skipped adds one cycle.
- Handshake at edge H:
  - DWELL occupies cycles H+1 … H+`DWELL_CYCLES`.
  - SEARCH starts at H+`DWELL_CYCLES`+1.
- Minimum request period for a single enabled channel with `ch_ready`=1 is `DWELL_CYCLES`+2 cycles.
- `busy` rises the cycle after the accepted `start` and falls the cycle the state returns to IDLE.

## Structure
- Package `demux_pkg`:
  - `N_CH`=32.
  - `CH_W`=5.
  - `DWELL_W`=24.
  - State enum `seq_state_t` {IDLE, SEARCH, ISSUE, DWELL}.
- Sub-module `dwell_timer`:
  - Loadable down-counter, parameter `W`.
  - Inputs: `load`, `load_val`. Output: `zero`.
  - Also reusable by the driver's clock divider.
- Top level holds the FSM, `mask_q`, `ptr`, `tried` and the output registers. Expected size ≈150–250 lines.

## Test plan
- `DWELL_CYCLES`=4, `ch_mask`=32'h0000_0005, `ch_ready`=1, `start` pulse → `ch` sequence 0,2,0,2…, with a `scan_done` pulse after each visit to channel 2. First `ch_valid` comes 2 cycles after the `start` edge. Gap between handshakes: 0→2 is 7 cycles, 2→0 is 35 cycles (29 disabled channels skipped).
- `ch_mask`=0, `start` → `busy` for 33 cycles, one `mask_err` pulse, `ch_valid` never asserted, return to IDLE.
- `ch_mask`=32'h8000_0001, `ch_ready` held 0 for 10 cycles in ISSUE → `ch_valid` stays 1 and `ch`=0 stays stable. Then `ch_ready`=1 → DWELL, and the next request is `ch`=31.
- `stop` asserted during DWELL → IDLE next edge, `busy` falls. `stop` asserted during ISSUE with `ch_ready`=0 → stays in ISSUE until ready, then IDLE with no DWELL.
- `rst` asserted mid-ISSUE and mid-DWELL → all outputs at their reset values next edge. A following `start` with a new `ch_mask` is latched correctly.
- `start`=`stop`=1 in IDLE → stays in IDLE. `ch_mask` changed while `busy` → sequence unaffected.
